dmem_access_unit: RTL and testbench

//   Data-memory stage of the 5-stage RV64 pipeline. Consumes the MEM-stage request (ALU address,

---
 rtl/dmem_access_unit_if.sv | 25 ++
 rtl/dmem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_dmem_access_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory unit (slave).
interface dmem_access_unit_if #(
  parameter int ADDR_BITS = 6
);
  logic                 req_valid;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [ADDR_BITS-1:0] req_addr;
  logic [63:0]          req_wdata;
  logic                 req_ready;
  logic                 stall;
  logic                 rsp_valid;
  logic [63:0]          rsp_rdata;
  logic                 err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, stall, rsp_valid, rsp_rdata, err
  );
endinterface

// File: rtl/dmem_access_unit.sv
// RV64 data-memory stage: little-endian 64-bit RAM, b/h/w/d loads and stores with fixed latency.
// Optional macro DMEM_MISALIGN_CHECK_EN reports misaligned accesses instead of aligning them.
module dmem_access_unit #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  dmem_access_unit_if.slave bus
);
  localparam int IDX_W = ADDR_BITS - 3;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 we_p0;
  logic [2:0]           funct3_p0;
  logic [ADDR_BITS-1:0] addr_p0;
  logic [63:0]          wdata_p0;
  logic [63:0]          rdata_p1;
  logic                 err_p1;
  logic [63:0]          mem [DEPTH];

  logic                 acc_we;
  logic [2:0]           acc_funct3;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [63:0]          acc_wdata;
  logic [IDX_W-1:0]     idx;
  logic [2:0]           off;
  logic                 illegal;
  logic                 bad;
  logic [63:0]          word, shifted, load_data, lane_msk, wdata_sh, new_word;
  logic                 enter_done;

  function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] v);
    logic signed [63:0] r;
    case (f3)
      3'b000:  r = signed'(v[7:0]);
      3'b001:  r = signed'(v[15:0]);
      3'b010:  r = signed'(v[31:0]);
      3'b011:  r = signed'(v);
      3'b100:  r = signed'({56'd0, v[7:0]});
      3'b101:  r = signed'({48'd0, v[15:0]});
      3'b110:  r = signed'({32'd0, v[31:0]});
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 64'h0000_0000_0000_00ff;
      2'd1:    return 64'h0000_0000_0000_ffff;
      2'd2:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] o);
    case (size)
      2'd1:    return o[0];
      2'd2:    return o[1:0] != 2'b00;
      2'd3:    return o != 3'b000;
      default: return 1'b0;
    endcase
  endfunction
`else
  function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] o);
    case (size)
      2'd1:    return {o[2:1], 1'b0};
      2'd2:    return {o[2], 2'b00};
      2'd3:    return 3'b000;
      default: return o;
    endcase
  endfunction
`endif

  // State register and access counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == BUSY && next_state == BUSY) cnt <= cnt + 1'b1;
      else                                     cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req_valid) next_state = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (cnt == CNT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.stall     = ((state == IDLE) && bus.req_valid) || (state == BUSY);
    bus.rsp_valid = (state == DONE);
  end

  // Stage p0: request capture on acceptance
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      we_p0     <= 1'b0;
      funct3_p0 <= '0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      we_p0     <= bus.req_we;
      funct3_p0 <= bus.req_funct3;
      addr_p0   <= bus.req_addr;
      wdata_p0  <= bus.req_wdata;
    end
  end

  // With zero wait cycles DONE is entered straight from IDLE, before the capture registers load.
  always_comb begin
    if (state == IDLE) begin
      acc_we     = bus.req_we;
      acc_funct3 = bus.req_funct3;
      acc_addr   = bus.req_addr;
      acc_wdata  = bus.req_wdata;
    end else begin
      acc_we     = we_p0;
      acc_funct3 = funct3_p0;
      acc_addr   = addr_p0;
      acc_wdata  = wdata_p0;
    end
  end

  always_comb begin
    idx     = acc_addr[ADDR_BITS-1:3];
    illegal = (acc_funct3 == 3'b111) || (acc_funct3[2] && acc_we);
`ifdef DMEM_MISALIGN_CHECK_EN
    off = acc_addr[2:0];
    bad = illegal || is_misaligned(acc_funct3[1:0], acc_addr[2:0]);
`else
    off = align_off(acc_funct3[1:0], acc_addr[2:0]);
    bad = illegal;
`endif
    word       = mem[idx];
    shifted    = word >> {off, 3'b000};
    load_data  = load_extend(acc_funct3, shifted);
    lane_msk   = size_mask(acc_funct3[1:0]) << {off, 3'b000};
    wdata_sh   = acc_wdata << {off, 3'b000};
    new_word   = (word & ~lane_msk) | (wdata_sh & lane_msk);
    enter_done = (next_state == DONE) && (state != DONE);
  end

  // Stage p1: response registers, loaded on the edge entering DONE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (enter_done) begin
      err_p1   <= bad;
      rdata_p1 <= (acc_we || bad) ? 64'd0 : load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (enter_done && acc_we && !bad && !RESET) mem[idx] <= new_word;
  end

  assign bus.rsp_rdata = rdata_p1;
  assign bus.err       = err_p1;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed test of dmem_access_unit: one instance with one wait cycle, one with zero.
module tb_dmem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_access_unit_if #(.ADDR_BITS(6)) bus ();
  dmem_access_unit_if #(.ADDR_BITS(6)) bus0 ();

  dmem_access_unit #(.ADDR_BITS(6), .WAIT_CYCLES(1)) u_dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );
  dmem_access_unit #(.ADDR_BITS(6), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(clk), .RESET(rst), .bus(bus0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit sel, input bit we, input logic [2:0] f3,
                        input logic [5:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic e,
                        output int lat, output int stl);
    bit got = 0;
    rd = '0; e = 1'b0; lat = 0; stl = 0;
    @(negedge clk);
    if (sel) begin
      bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
      bus0.req_addr = addr; bus0.req_wdata = wd;
    end else begin
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
    end
    #1;
    if (sel ? bus0.stall : bus.stall) stl++;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? bus0.stall : bus.stall) stl++;
      if (sel ? bus0.rsp_valid : bus.rsp_valid) begin
        got = 1;
        rd  = sel ? bus0.rsp_rdata : bus.rsp_rdata;
        e   = sel ? bus0.err : bus.err;
      end
    end
    bus.req_valid  = 1'b0;
    bus0.req_valid = 1'b0;
    if (!got) chk("timeout", 64'd0, 64'd1);
  endtask

  logic [63:0] rd;
  logic        e;
  int          lat, stl, nrsp;

  initial begin
    bus.req_valid = 0;  bus.req_we = 0;  bus.req_funct3 = 0;  bus.req_addr = 0;  bus.req_wdata = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_funct3 = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_rsp",   {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_err",   {63'd0, bus.err}, 64'd0);
    rst = 1'b0;

    // sd / ld round trip with latency and stall length
    access(0, 1, 3'b011, 6'h08, 64'h8877665544332211, rd, e, lat, stl);
    chk("sd_rdata", rd, 64'd0);
    chk("sd_err", {63'd0, e}, 64'd0);
    chk("sd_lat", 64'(lat), 64'd2);
    chk("sd_stall", 64'(stl), 64'd2);
    access(0, 0, 3'b011, 6'h08, 64'd0, rd, e, lat, stl);
    chk("ld_rdata", rd, 64'h8877665544332211);
    chk("ld_lat", 64'(lat), 64'd2);
    chk("ld_stall", 64'(stl), 64'd2);
    @(negedge clk);
    chk("rsp_pulse", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rdata_hold", bus.rsp_rdata, 64'h8877665544332211);

    // sub-word loads with extension
    access(0, 0, 3'b000, 6'h0F, 64'd0, rd, e, lat, stl); chk("lb", rd, 64'hFFFFFFFFFFFFFF88);
    access(0, 0, 3'b100, 6'h0F, 64'd0, rd, e, lat, stl); chk("lbu", rd, 64'h88);
    access(0, 0, 3'b001, 6'h0E, 64'd0, rd, e, lat, stl); chk("lh", rd, 64'hFFFFFFFFFFFF8877);
    access(0, 0, 3'b101, 6'h0E, 64'd0, rd, e, lat, stl); chk("lhu", rd, 64'h8877);
    access(0, 0, 3'b010, 6'h0C, 64'd0, rd, e, lat, stl); chk("lw", rd, 64'hFFFFFFFF88776655);
    access(0, 0, 3'b110, 6'h0C, 64'd0, rd, e, lat, stl); chk("lwu", rd, 64'h0000000088776655);

    // byte store touches one lane only
    access(0, 1, 3'b000, 6'h09, 64'h123456789ABCDEAA, rd, e, lat, stl);
    chk("sb_err", {63'd0, e}, 64'd0);
    access(0, 0, 3'b011, 6'h08, 64'd0, rd, e, lat, stl); chk("sb_ld", rd, 64'h887766554433AA11);

    // misaligned word load
    access(0, 0, 3'b010, 6'h0A, 64'd0, rd, e, lat, stl);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("lw_mis_err", {63'd0, e}, 64'd1);
    chk("lw_mis_rdata", rd, 64'd0);
`else
    chk("lw_mis_err", {63'd0, e}, 64'd0);
    chk("lw_mis_rdata", rd, 64'h000000004433AA11);
`endif

    // illegal store funct3 must not write
    access(0, 1, 3'b100, 6'h08, 64'hFFFFFFFFFFFFFFFF, rd, e, lat, stl);
    chk("ill_st_err", {63'd0, e}, 64'd1);
    chk("ill_st_rdata", rd, 64'd0);
    access(0, 0, 3'b011, 6'h08, 64'd0, rd, e, lat, stl); chk("ill_st_ram", rd, 64'h887766554433AA11);
    chk("err_clear", {63'd0, e}, 64'd0);

    // reset during BUSY discards the pending store
    access(0, 1, 3'b011, 6'h10, 64'd0, rd, e, lat, stl);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b011;
    bus.req_addr = 6'h10; bus.req_wdata = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    chk("busy_stall", {63'd0, bus.stall}, 64'd1);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    nrsp = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
    chk("rst_busy_rsp", 64'(nrsp), 64'd0);
    chk("rst_busy_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_busy_rdata", bus.rsp_rdata, 64'd0);
    access(0, 0, 3'b011, 6'h10, 64'd0, rd, e, lat, stl); chk("rst_busy_ram", rd, 64'd0);

    // zero-wait instance
    access(1, 1, 3'b011, 6'h18, 64'h0123456789ABCDEF, rd, e, lat, stl);
    chk("w0_sd_lat", 64'(lat), 64'd1);
    access(1, 0, 3'b011, 6'h18, 64'd0, rd, e, lat, stl);
    chk("w0_ld", rd, 64'h0123456789ABCDEF);
    chk("w0_lat", 64'(lat), 64'd1);
    chk("w0_stall", 64'(stl), 64'd1);
    access(1, 0, 3'b111, 6'h18, 64'd0, rd, e, lat, stl);
    chk("w0_f7_err", {63'd0, e}, 64'd1);
    chk("w0_f7_rdata", rd, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
